alu_multicycle: RTL

- Parametrised successor to the single-cycle datapath ALU, for the multi-cycle MIPS datapath.
- Adds a start/busy/done handshake, iterative unsigned MUL producing a full 2*WIDTH product, and iterative unsigned DIV with a divide-by-zero flag.
- SLT is now signed. All outputs are registered.
- The control FSM holds off PC/register-file write-back until done.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/alu_multicycle.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and helpers for the multi-cycle ALU.
// Imported by the top level and by the iterative MUL/DIV engine.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_XOR = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_DIV = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_div_op(input logic [2:0] op);
      return op == ALU_DIV;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo present the value the registers take at the next edge, so the caller can capture the final step directly.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             last
);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [WIDTH-1:0] div_hi, div_lo;
   logic [WIDTH-1:0] step_hi, step_lo;

   // MUL: {hi,lo} is the product register with the multiplier shifting out of lo.
   // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};

      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, m_q};
      div_sub   = div_shift[WIDTH-1:0] - m_q;
      div_hi    = div_ge ? div_sub : div_shift[WIDTH-1:0];
      div_lo    = {lo_q[WIDTH-2:0], div_ge};

      step_hi   = div_q ? div_hi : mul_hi;
      step_lo   = div_q ? div_lo : mul_lo;
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      m_d   = m_q;
      div_d = div_q;
      cnt_d = cnt_q;
      if (load) begin
         div_d = is_div_op(op);
         hi_d  = '0;
         lo_d  = is_div_op(op) ? a : b;
         m_d   = is_div_op(op) ? b : a;
         cnt_d = CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         m_q   <= m_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign hi   = step_hi;
   assign lo   = step_lo;
   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with start/busy/done handshake: single-cycle logic/arith ops,
// iterative unsigned MUL (full product) and DIV (quotient/remainder, divide-by-zero flag).
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] alu_hi,
   output logic             zero_flag,
   output logic             div_by_zero,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] simple_result;
   logic             iter_load;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic             iter_last;

   alu_muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk   (clk),
      .reset (reset),
      .load  (iter_load),
      .op    (alu_control),
      .a     (srca),
      .b     (srcb),
      .hi    (iter_hi),
      .lo    (iter_lo),
      .last  (iter_last)
   );

   always_comb begin
      case (alu_control)
         ALU_AND: simple_result = srca & srcb;
         ALU_XOR: simple_result = srca ^ srcb;
         ALU_ADD: simple_result = srca + srcb;
         ALU_OR:  simple_result = srca | srcb;
         ALU_SUB: simple_result = srca - srcb;
         ALU_SLT: simple_result = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
         default: simple_result = '0;
      endcase
   end

   // Output registers only move on the edge that enters DONE; everything else holds.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      hi_d      = hi_q;
      zero_d    = zero_q;
      dbz_d     = dbz_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      iter_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (alu_control == ALU_MUL) begin
                  state_d   = ST_MUL;
                  busy_d    = 1'b1;
                  iter_load = 1'b1;
               end else if (alu_control == ALU_DIV && srcb != '0) begin
                  state_d   = ST_DIV;
                  busy_d    = 1'b1;
                  iter_load = 1'b1;
               end else if (alu_control == ALU_DIV) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = '1;
                  hi_d     = srca;
                  zero_d   = 1'b0;
                  dbz_d    = 1'b1;
               end else begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = simple_result;
                  hi_d     = '0;
                  zero_d   = (simple_result == '0);
                  dbz_d    = 1'b0;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (iter_last) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               result_d = iter_lo;
               hi_d     = iter_hi;
               zero_d   = (iter_lo == '0);
               dbz_d    = 1'b0;
            end else begin
               busy_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign alu_result  = result_q;
   assign alu_hi      = hi_q;
   assign zero_flag   = zero_q;
   assign div_by_zero = dbz_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
